// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, clear FSM states and write-port priority helper
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int MAX_NW   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } wp_match_t;

  // Later ports overwrite earlier ones, so the highest matching index wins.
  function automatic wp_match_t hi_match(input logic [MAX_NW-1:0] hits);
    wp_match_t m;
    m = '0;
    for (int k = 0; k < MAX_NW; k++) begin
      if (hits[k]) begin
        m.hit = 1'b1;
        m.idx = 2'(k);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for pipeline hazard tracking
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG    = DEF_NREG,
  parameter int NW      = 1,
  parameter int ZERO_R0 = 1,
  parameter int AW      = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_en_i,
  input  logic [AW-1:0]    issue_a_i,
  input  logic [NW-1:0]    commit_i,
  input  logic [NW*AW-1:0] commit_a_i,
  input  logic             sweep_i,
  input  logic [AW-1:0]    sweep_a_i,
  output logic [NREG-1:0]  busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  // Issue is applied after writeback clears so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (sweep_i) begin
      busy_d[sweep_a_i] = 1'b0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (commit_i[k]) busy_d[commit_a_i[k*AW +: AW]] = 1'b0;
      end
      if (issue_en_i) busy_d[issue_a_i] = 1'b1;
    end
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, busy scoreboard and clear sweep
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN    = DEF_XLEN,
  parameter int  NREG    = DEF_NREG,
  parameter int  NR      = 2,
  parameter int  NW      = 1,
  parameter int  BYPASS  = 1,
  parameter int  ZERO_R0 = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NR*AW-1:0]   RA,
  output logic [NR*XLEN-1:0] RD,
  input  logic [NW-1:0]      WE,
  input  logic [NW*AW-1:0]   WA,
  input  logic [NW*XLEN-1:0] WD,
  input  logic               ISSUE_EN,
  input  logic [AW-1:0]      ISSUE_A,
  output logic [NREG-1:0]    BUSY,
  input  logic               CLR_REQ,
  output logic               CLR_BUSY
);

  clr_state_e        state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              sweep;
  logic [NW-1:0]     commit;
  logic [XLEN-1:0]   mem_q [NREG];

  assign sweep    = (state_q == SWEEP);
  assign CLR_BUSY = sweep;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A write only counts when it will actually land in the array.
  always_comb begin
    commit = '0;
    for (int k = 0; k < NW; k++) begin
      commit[k] = WE[k] && !sweep && !((ZERO_R0 != 0) && (WA[k*AW +: AW] == '0));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (sweep) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (commit[k]) mem_q[WA[k*AW +: AW]] <= WD[k*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [MAX_NW-1:0] hits;
    wp_match_t         m;
    logic [XLEN-1:0]   byp;
    logic [XLEN-1:0]   rd;

    assign ra = RA[i*AW +: AW];

    always_comb begin
      hits = '0;
      for (int k = 0; k < NW; k++) hits[k] = commit[k] && (WA[k*AW +: AW] == ra);
      m   = hi_match(hits);
      byp = '0;
      for (int k = 0; k < NW; k++) begin
        if (2'(k) == m.idx) byp = WD[k*XLEN +: XLEN];
      end
      if ((ZERO_R0 != 0) && (ra == '0)) rd = '0;
      else if ((BYPASS != 0) && m.hit)  rd = byp;
      else                              rd = mem_q[ra];
    end

    assign RD[i*XLEN +: XLEN] = rd;
  end

  regfile_scoreboard #(
    .NREG    (NREG),
    .NW      (NW),
    .ZERO_R0 (ZERO_R0),
    .AW      (AW)
  ) u_scoreboard (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .issue_en_i (ISSUE_EN),
    .issue_a_i  (ISSUE_A),
    .commit_i   (commit),
    .commit_a_i (WA),
    .sweep_i    (sweep),
    .sweep_a_i  (cnt_q),
    .busy_o     (BUSY)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - two-configuration bench with a behavioural register-file model
module tb_regfile_mp;

  localparam int XL  = 32;
  localparam int NRG = 32;
  localparam int AWL = 5;

  logic              clk;
  logic              rst_n;
  logic [2*AWL-1:0]  ra;
  logic [1:0]        we;
  logic [2*AWL-1:0]  wa;
  logic [2*XL-1:0]   wd;
  logic              issue_en;
  logic [AWL-1:0]    issue_a;
  logic              clr_req;
  logic [2*XL-1:0]   rd_a, rd_b;
  logic [NRG-1:0]    busy_a, busy_b;
  logic              clrb_a, clrb_b;

  // dut_a: two write ports, bypass, hardwired r0. dut_b: one write port, no bypass, writable r0.
  regfile_mp #(.XLEN(XL), .NREG(NRG), .NR(2), .NW(2), .BYPASS(1), .ZERO_R0(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .RA(ra), .RD(rd_a), .WE(we), .WA(wa), .WD(wd),
    .ISSUE_EN(issue_en), .ISSUE_A(issue_a), .BUSY(busy_a), .CLR_REQ(clr_req), .CLR_BUSY(clrb_a)
  );

  regfile_mp #(.XLEN(XL), .NREG(NRG), .NR(2), .NW(1), .BYPASS(0), .ZERO_R0(0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .RA(ra), .RD(rd_b), .WE(we[0]), .WA(wa[AWL-1:0]), .WD(wd[XL-1:0]),
    .ISSUE_EN(issue_en), .ISSUE_A(issue_a), .BUSY(busy_b), .CLR_REQ(clr_req), .CLR_BUSY(clrb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [XL-1:0]  m_a [NRG];
  logic [XL-1:0]  m_b [NRG];
  logic [NRG-1:0] mb_a, mb_b;
  int             pos;
  int             tests;
  int             fails;
  int             n;
  bit             chk_on;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NRG; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    mb_a = '0;
    mb_b = '0;
    pos  = -1;
  endtask

  // pos < 0 means idle; otherwise it is the register the next sweep edge clears.
  task automatic model_tick();
    if (!rst_n) return;
    if (pos >= 0) begin
      m_a[pos]  = '0;
      m_b[pos]  = '0;
      mb_a[pos] = 1'b0;
      mb_b[pos] = 1'b0;
      pos++;
      if (pos == NRG) pos = -1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we[k] && wa[k*AWL +: AWL] != 0) begin
          m_a[wa[k*AWL +: AWL]]  = wd[k*XL +: XL];
          mb_a[wa[k*AWL +: AWL]] = 1'b0;
        end
      end
      if (we[0]) begin
        m_b[wa[AWL-1:0]]  = wd[XL-1:0];
        mb_b[wa[AWL-1:0]] = 1'b0;
      end
      if (issue_en) begin
        if (issue_a != 0) mb_a[issue_a] = 1'b1;
        mb_b[issue_a] = 1'b1;
      end
      if (clr_req) pos = 0;
    end
  endtask

  function automatic logic [XL-1:0] exp_a(input logic [AWL-1:0] r);
    if (r == 0) return '0;
    if (pos < 0) begin
      for (int k = 1; k >= 0; k--) begin
        if (we[k] && wa[k*AWL +: AWL] == r) return wd[k*XL +: XL];
      end
    end
    return m_a[r];
  endfunction

  function automatic logic [XL-1:0] exp_b(input logic [AWL-1:0] r);
    return m_b[r];
  endfunction

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic quiet();
    we       = '0;
    issue_en = 1'b0;
    clr_req  = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_on) begin
      check("rd_a0", 64'(rd_a[XL-1:0]), 64'(exp_a(ra[AWL-1:0])));
      check("rd_a1", 64'(rd_a[2*XL-1:XL]), 64'(exp_a(ra[2*AWL-1:AWL])));
      check("rd_b0", 64'(rd_b[XL-1:0]), 64'(exp_b(ra[AWL-1:0])));
      check("rd_b1", 64'(rd_b[2*XL-1:XL]), 64'(exp_b(ra[2*AWL-1:AWL])));
      check("busy_a", 64'(busy_a), 64'(mb_a));
      check("busy_b", 64'(busy_b), 64'(mb_b));
      check("clr_busy_a", 64'(clrb_a), 64'(pos >= 0));
      check("clr_busy_b", 64'(clrb_b), 64'(pos >= 0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired before summary");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; chk_on = 1'b0;
    rst_n = 1'b0; ra = '0; wa = '0; wd = '0; issue_a = '0;
    quiet();
    model_reset();
    step(); step();
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_clrb", 64'(clrb_a), 64'd0);
    check("reset_rd", rd_a, 64'd0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h1234}; issue_en = 1'b1; issue_a = 5'd6;
    step(); quiet();
    ra = {5'd0, 5'd5};
    #1;
    check("r5_written", 64'(rd_a[XL-1:0]), 64'h1234);
    check("busy6_set", 64'(busy_a[6]), 64'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rd_a_r5", 64'(rd_a[XL-1:0]), 64'd0);
    check("async_rd_b_r5", 64'(rd_b[XL-1:0]), 64'd0);
    check("async_busy", 64'(busy_a), 64'd0);
    check("async_clrb", 64'(clrb_a), 64'd0);
    step();
    rst_n = 1'b1;

    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd0, 5'd7};
    #1;
    check("bypass_a", 64'(rd_a[XL-1:0]), 64'hDEADBEEF);
    check("nobypass_b", 64'(rd_b[XL-1:0]), 64'd0);
    step(); quiet();
    #1;
    check("held_a", 64'(rd_a[XL-1:0]), 64'hDEADBEEF);
    check("held_b", 64'(rd_b[XL-1:0]), 64'hDEADBEEF);

    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFFFFFF}; issue_en = 1'b1; issue_a = 5'd0; ra = '0;
    step(); quiet();
    #1;
    check("r0_a", 64'(rd_a[XL-1:0]), 64'd0);
    check("busy0_a", 64'(busy_a[0]), 64'd0);
    check("r0_b", 64'(rd_b[XL-1:0]), 64'hFFFFFFFF);
    check("busy0_b", 64'(busy_b[0]), 64'd1);

    we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'hBBBB, 32'hAAAA}; ra = {5'd3, 5'd0};
    #1;
    check("conflict_byp_a", 64'(rd_a[2*XL-1:XL]), 64'hBBBB);
    check("conflict_old_b", 64'(rd_b[2*XL-1:XL]), 64'd0);
    step(); quiet();
    #1;
    check("conflict_a", 64'(rd_a[2*XL-1:XL]), 64'hBBBB);
    check("conflict_b", 64'(rd_b[2*XL-1:XL]), 64'hAAAA);

    issue_en = 1'b1; issue_a = 5'd9;
    step(); quiet();
    #1;
    check("issue9_a", 64'(busy_a[9]), 64'd1);
    check("issue9_b", 64'(busy_b[9]), 64'd1);
    we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h99, 32'h0};
    step(); quiet();
    #1;
    check("write9_a", 64'(busy_a[9]), 64'd0);
    check("write9_b", 64'(busy_b[9]), 64'd1);
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h999}; issue_en = 1'b1; issue_a = 5'd9;
    step(); quiet();
    #1;
    check("issue_write9_a", 64'(busy_a[9]), 64'd1);
    check("issue_write9_b", 64'(busy_b[9]), 64'd1);

    for (int r = 1; r < NRG; r++) begin
      we       = (r % 3 == 0) ? 2'b11 : 2'b01;
      wa       = {5'((r * 7) % NRG), 5'(r)};
      wd       = {~32'(r), 32'h10000000 + 32'(r) * 32'h0101};
      issue_en = r[0];
      issue_a  = 5'(r + 2);
      ra       = {5'(r - 1), 5'(r)};
      step();
    end
    quiet();
    step();

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clrb_a && n < 100) begin
      n++;
      clr_req  = (n == 10);
      we       = 2'b11;
      wa       = {5'(n), 5'(n + 3)};
      wd       = {$urandom, $urandom};
      issue_en = 1'b1;
      issue_a  = 5'(n);
      ra       = {5'(n), 5'(n + 3)};
      step();
    end
    quiet();
    check("sweep_len_a", 64'(n), 64'd32);
    check("sweep_done_b", 64'(clrb_b), 64'd0);
    for (int r = 0; r < NRG; r++) begin
      ra = {5'(r), 5'(r)};
      #1;
      check("post_clear_a", rd_a, 64'd0);
      check("post_clear_b", rd_b, 64'd0);
    end
    check("post_clear_busy_a", 64'(busy_a), 64'd0);
    check("post_clear_busy_b", 64'(busy_b), 64'd0);

    we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'd0, 32'h55}; ra = {5'd0, 5'd4};
    #1;
    check("bypass_after_clear", 64'(rd_a[XL-1:0]), 64'h55);
    step(); quiet();
    step(); step();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
